// File: rtl/dcache_mem_responder.sv
// ---------------------------------------------------------------------------
// dcache_mem_responder
//
// Behavioural backing memory for a data-cache controller. It accepts one
// request at a time, waits a fixed number of cycles and then pulses a
// one-cycle response. Reads return the stored 128-bit line. Writes store the
// line when the response is given and echo that line back to the cache.
//
// Ports
//   clock     : single clock, rising edge
//   reset     : asynchronous, active-low reset
//   mem_req   : request from the cache (addr, data, rw = 1 for write, valid)
//   mem_data  : response to the cache (data, ready)
//   busy      : registered, high while a request is outstanding
//   rd_count  : number of completed reads (wraps)
//   wr_count  : number of completed writes (wraps)
// ---------------------------------------------------------------------------

package dcache_mem_pkg;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;

endpackage

// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | nothing outstanding; a valid pulse is captured
// WAIT     | request captured; latency counter running, valid ignored
// RESPOND  | ready high for one cycle; write committed on leaving edge;
//          | a valid pulse here is captured as the next request
module dcache_mem_responder
    import dcache_mem_pkg::*;
#(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LINES = 256
) (
    input  logic         clock,
    input  logic         reset,
    input  mem_req_type  mem_req,
    output mem_data_type mem_data,
    output logic         busy,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count
);

    localparam int         IDX_W  = $clog2(DEPTH_LINES);
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    logic [1:0]       r_state;
    logic [7:0]       r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [127:0]     r_data;
    logic             r_rw;
    logic             r_busy;
    logic [31:0]      r_rd_count;
    logic [31:0]      r_wr_count;

    logic [127:0]     r_mem [DEPTH_LINES];

    logic [1:0]       w_state_nxt;
    logic [7:0]       w_cnt_nxt;
    logic             w_capture;
    logic             w_mem_we;
    logic [IDX_W-1:0] w_req_idx;
    logic             w_unused;

    // Offset bits and aliasing high bits do not take part in addressing.
    assign w_req_idx = mem_req.addr[4 +: IDX_W];
    assign w_unused  = ^{mem_req.addr[3:0], mem_req.addr[31:4+IDX_W]};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_req.valid) begin
                    w_capture = 1'b1;
                end
            end
            S_WAIT: begin
                // The counter is loaded with LATENCY-1 on capture; RESPOND is
                // entered on the edge where it reaches zero, so ready is seen
                // by the requester on the LATENCY-th edge after capture.
                if (r_cnt <= 8'd1) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_RESPOND;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_RESPOND: begin
                if (mem_req.valid) begin
                    w_capture = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase

        if (w_capture) begin
            w_cnt_nxt   = LAT_M1;
            w_state_nxt = (LATENCY == 1) ? S_RESPOND : S_WAIT;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_idx      <= '0;
            r_data     <= '0;
            r_rw       <= 1'b0;
            r_busy     <= 1'b0;
            r_rd_count <= 32'd0;
            r_wr_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            if (w_capture) begin
                r_idx  <= w_req_idx;
                r_data <= mem_req.data;
                r_rw   <= mem_req.rw;
            end
            if (r_state == S_RESPOND) begin
                if (r_rw) begin
                    r_wr_count <= r_wr_count + 32'd1;
                end else begin
                    r_rd_count <= r_rd_count + 32'd1;
                end
            end
        end
    end

    // Storage has no reset. The write enable is qualified by the FSM state,
    // which reset forces to IDLE, so an aborted write never lands.
    assign w_mem_we = (r_state == S_RESPOND) && r_rw;

    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_data;
        end
    end

    // A read that follows a write to the same line sees the updated entry
    // because the write lands on the edge that enters the read's WAIT/RESPOND.
    always_comb begin
        mem_data = '0;
        if (r_state == S_RESPOND) begin
            mem_data.ready = 1'b1;
            mem_data.data  = r_rw ? r_data : r_mem[r_idx];
        end
    end

    assign busy     = r_busy;
    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;

endmodule

// File: doc/dcache_mem_responder.md
DCACHE_MEM_RESPONDER -- requirements
Module: dcache_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request capture to the response pulse; legal range 1..255.
REQ-002 SHALL have parameter DEPTH_LINES, default 256: number of 128-bit lines stored; power of two, 2..4096.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low (0 = reset asserted).
REQ-005 SHALL have port mem_req, input, mem_req_type: addr[31:0], data[127:0], rw (1 = write), valid; driven by the data-cache controller.
REQ-006 SHALL have port mem_data, output, mem_data_type: data[127:0], ready; the response to the cache.
REQ-007 SHALL have port busy, output, 1 bit: high while a request is outstanding (WAIT or RESPOND).
REQ-008 SHALL have port rd_count, output, 32 bits: number of completed reads.
REQ-009 SHALL have port wr_count, output, 32 bits: number of completed writes.

Function
REQ-010 SHALL store DEPTH_LINES x 128-bit lines; index = addr[4 +: log2(DEPTH_LINES)]; addr[3:0] is ignored; higher address bits alias.
REQ-011 SHALL implement the FSM states IDLE, WAIT and RESPOND; at most one request is outstanding.
REQ-012 In IDLE, when mem_req.valid = 1, SHALL capture addr, data and rw; load the latency counter with LATENCY-1; go to WAIT (LATENCY = 1 goes straight to RESPOND).
REQ-013 Request capture SHALL use a single-cycle valid pulse; the requester does not hold valid, and the captured values are used thereafter.
REQ-014 In WAIT, SHALL decrement the counter each cycle and enter RESPOND when the counter reaches 0, so that ready rises exactly LATENCY cycles after the capture edge.
REQ-015 In RESPOND, SHALL drive mem_data.ready = 1 for exactly one cycle.
REQ-016 On a read response, mem_data.data SHALL equal the stored line at the captured index.
REQ-017 On a write, SHALL write the captured 128-bit line at the RESPOND edge; mem_data.data SHALL echo the written line.
REQ-018 In RESPOND, if mem_req.valid = 1 in that same cycle (write-back followed immediately by line fill), SHALL capture it as a new request and go to WAIT/RESPOND per REQ-012; otherwise go to IDLE.
REQ-019 A read captured in RESPOND immediately after a write to the same index SHALL return the newly written data.
REQ-020 mem_req.valid in WAIT SHALL be ignored: no capture and no error.
REQ-021 Outside RESPOND, mem_data.ready SHALL be 0 and mem_data.data SHALL be 0.
REQ-022 rd_count/wr_count SHALL increment by 1 at the RESPOND edge of a read/write respectively, wrapping modulo 2^32.
REQ-023 busy SHALL be registered and equal (state != IDLE).

Reset
REQ-024 While reset = 0: state = IDLE, counter = 0, mem_data = 0, busy = 0, rd_count = 0, wr_count = 0, asynchronously.
REQ-025 Reset asserted mid-operation SHALL abort the outstanding request with no response pulse; an aborted write SHALL NOT modify storage.
REQ-026 Storage contents SHALL NOT be affected by reset; they are zero at time 0.
REQ-027 After reset is deasserted, the first rising edge SHALL be able to capture a request.

Verification
REQ-028 Read at time 0, addr 0x0000_0040, LATENCY 4 -> ready high for 1 cycle exactly 4 cycles after the capture edge, data = 0, rd_count = 1.
REQ-029 Write addr 0x30, data 0xDEADBEEF_00000001_CAFEF00D_12345678, then read addr 0x3C -> read returns the same 128-bit line; wr_count = 1, rd_count = 1.
REQ-030 Write to 0x50 with a read of 0x50 pulsed in the write's RESPOND cycle -> read is captured with no idle gap and returns the written data 2xLATENCY cycles after the write capture.
REQ-031 Pulse valid again during WAIT -> ignored: only one response, counters advance by 1.
REQ-032 Write in flight, reset = 0 for 1 cycle during WAIT -> no ready pulse, counters = 0, a later read of that index returns the old data.
REQ-033 LATENCY = 1: back-to-back reads of 0x0 and 0x10, each pulsed in the preceding RESPOND cycle -> ready high on consecutive capture+1 cycles with correct data each.
